// File: rtl/cpu_ctrl.sv
// cpu_ctrl: instruction register, immediate sign-extension and the
// multi-cycle control FSM that sequences the register-file/ALU datapath.
// Optional build macro CPU_CTRL_ILLEGAL_TRAP_EN: when defined, an illegal
// instruction parks the FSM in ERR (err=1, w=0) until reset; when
// undefined, illegal instructions fall back to WAIT and err is tied low.
module cpu_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        err,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        WAIT   = 3'd0,
        DECODE = 3'd1,
        GET_A  = 3'd2,
        GET_B  = 3'd3,
        EXEC   = 3'd4,
        WR_REG = 3'd5,
        WR_IMM = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t      state, next;
    logic [15:0] ir;

    // Instruction fields
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    logic is_alu, is_cmp;
    assign is_alu = (opcode == 3'b101);
    assign is_cmp = is_alu && (op == 2'b01);

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    assign err = (state == ERR);
`else
    assign err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT;
        else          state <= next;
    end

    // IR captures only while idle; load is ignored mid-instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     ir <= 16'h0000;
        else if (load && state == WAIT)   ir <= in;
    end

    // Next-state and Moore outputs; anything not driven in a state stays 0
    always_comb begin
        next     = state;
        w        = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'b00;
        writenum = 3'd0;
        readnum  = 3'd0;
        write    = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        case (state)
            WAIT: begin
                w = 1'b1;
                if (s) next = DECODE;
            end
            DECODE: begin
                if (opcode == 3'b110 && op == 2'b10)      next = WR_IMM;
                else if (opcode == 3'b110 && op == 2'b00) next = GET_B;
                else if (is_alu && op == 2'b11)           next = GET_B;
                else if (is_alu)                          next = GET_A;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                else                                      next = ERR;
`else
                else                                      next = WAIT;
`endif
            end
            GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                next    = GET_B;
            end
            GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                next    = EXEC;
            end
            EXEC: begin
                shift = sh;
                if (is_alu) ALUop = op;
                else        asel  = 1'b1;   // MOV reg: 0 + shifted B
                if (is_cmp) begin
                    loads = 1'b1;
                    next  = WAIT;
                end else begin
                    loadc = 1'b1;
                    next  = WR_REG;
                end
            end
            WR_REG: begin
                vsel     = 2'b00;
                writenum = rd;
                write    = 1'b1;
                next     = WAIT;
            end
            WR_IMM: begin
                vsel     = 2'b10;
                writenum = rn;
                write    = 1'b1;
                next     = WAIT;
            end
            ERR: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                next = ERR;
`else
                next = WAIT;
`endif
            end
            default: next = WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: walks each instruction class edge by edge
// and compares the full control-output vector against hand-built values.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in;
    logic        load, s;
    logic        w, err, loada, loadb, loadc, loads, asel, bsel, write;
    logic [1:0]  vsel, shift, ALUop;
    logic [2:0]  writenum, readnum;
    logic [15:0] sximm8, sximm5;

    int checks   = 0;
    int failures = 0;

    cpu_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s),
        .w(w), .err(err), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
        .writenum(writenum), .readnum(readnum), .write(write),
        .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // {w,err,loada,loadb,loadc,loads,asel,bsel,vsel,writenum,readnum,write,shift,ALUop}
    function automatic logic [20:0] obs();
        return {w, err, loada, loadb, loadc, loads, asel, bsel, vsel,
                writenum, readnum, write, shift, ALUop};
    endfunction

    function automatic logic [20:0] ex(input logic ew, ee, la, lb, lc, ls, as,
                                       input logic [1:0] vs, input logic [2:0] wn, rn,
                                       input logic wr, input logic [1:0] sh, alu);
        return {ew, ee, la, lb, lc, ls, as, 1'b0, vs, wn, rn, wr, sh, alu};
    endfunction

    logic [20:0] idle_v, dec_v;
    logic [20:0] seq [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] instr);
        in = instr; load = 1'b1; s = 1'b1;
        step();
        load = 1'b0; s = 1'b0; in = 16'h0000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load = 1'b1; s = 1'b1; in = 16'hFFFF;
        repeat (3) step();
        checks++;
        if (obs() !== idle_v || sximm8 !== 16'h0000) begin
            $display("FAIL reset_hold got=%h/%h exp=%h/0000", obs(), sximm8, idle_v);
            failures++;
        end
        load = 1'b0; s = 1'b0; in = 16'h0000;
        #2 reset_n = 1'b1;
        step();
        checks++;
        if (obs() !== idle_v || sximm8 !== 16'h0000) begin
            $display("FAIL reset_release got=%h/%h exp=%h/0000", obs(), sximm8, idle_v);
            failures++;
        end
    endtask

    task automatic test_mov_imm();
        seq[0] = dec_v;
        seq[1] = ex(0,0,0,0,0,0,0,2'b10,3'd0,3'd0,1,2'b00,2'b00);
        seq[2] = idle_v;
        issue(16'hD0FB);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs() !== seq[i]) begin
                $display("FAIL mov_imm edge%0d got=%h exp=%h", i + 1, obs(), seq[i]);
                failures++;
            end
            if (i < 2) step();
        end
        checks++;
        if (sximm8 !== 16'hFFFB || sximm5 !== 16'hFFFB) begin
            $display("FAIL mov_imm_sx got=%h/%h exp=FFFB/FFFB", sximm8, sximm5);
            failures++;
        end
    endtask

    task automatic test_add();
        seq[0] = dec_v;
        seq[1] = ex(0,0,1,0,0,0,0,2'b00,3'd0,3'd1,0,2'b00,2'b00);
        seq[2] = ex(0,0,0,1,0,0,0,2'b00,3'd0,3'd0,0,2'b00,2'b00);
        seq[3] = ex(0,0,0,0,1,0,0,2'b00,3'd0,3'd0,0,2'b01,2'b00);
        seq[4] = ex(0,0,0,0,0,0,0,2'b00,3'd2,3'd0,1,2'b00,2'b00);
        seq[5] = idle_v;
        issue(16'hA148);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs() !== seq[i]) begin
                $display("FAIL add edge%0d got=%h exp=%h", i + 1, obs(), seq[i]);
                failures++;
            end
            if (i == 1) begin in = 16'h00FF; load = 1'b1; end  // must be ignored
            if (i < 5) step();
            load = 1'b0;
        end
        checks++;
        if (sximm8 !== 16'h0048) begin
            $display("FAIL add_load_ignored got=%h exp=0048", sximm8);
            failures++;
        end
    endtask

    task automatic test_mov_reg();
        seq[0] = dec_v;
        seq[1] = ex(0,0,0,1,0,0,0,2'b00,3'd0,3'd1,0,2'b00,2'b00);
        seq[2] = ex(0,0,0,0,1,0,1,2'b00,3'd0,3'd0,0,2'b00,2'b00);
        seq[3] = ex(0,0,0,0,0,0,0,2'b00,3'd2,3'd0,1,2'b00,2'b00);
        seq[4] = idle_v;
        issue(16'hC041);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs() !== seq[i]) begin
                $display("FAIL mov_reg edge%0d got=%h exp=%h", i + 1, obs(), seq[i]);
                failures++;
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_cmp();
        seq[0] = dec_v;
        seq[1] = ex(0,0,1,0,0,0,0,2'b00,3'd0,3'd1,0,2'b00,2'b00);
        seq[2] = ex(0,0,0,1,0,0,0,2'b00,3'd0,3'd0,0,2'b00,2'b00);
        seq[3] = ex(0,0,0,0,0,1,0,2'b00,3'd0,3'd0,0,2'b00,2'b01);
        seq[4] = idle_v;
        issue(16'hA900);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs() !== seq[i]) begin
                $display("FAIL cmp edge%0d got=%h exp=%h", i + 1, obs(), seq[i]);
                failures++;
            end
            if (i < 4) step();
        end
    endtask

    task automatic test_mvn_reset_abort();
        issue(16'hB861);
        step();  // GET_B
        checks++;
        if (obs() !== ex(0,0,0,1,0,0,0,2'b00,3'd0,3'd1,0,2'b00,2'b00)) begin
            $display("FAIL mvn_get_b got=%h", obs());
            failures++;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== idle_v || sximm8 !== 16'h0000 || sximm5 !== 16'h0000) begin
            $display("FAIL mvn_async_reset got=%h/%h exp=%h/0000", obs(), sximm8, idle_v);
            failures++;
        end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs() !== idle_v) begin
                $display("FAIL mvn_post_abort edge%0d got=%h exp=%h", i, obs(), idle_v);
                failures++;
            end
        end
    endtask

    task automatic test_illegal();
        issue(16'h0000);
        checks++;
        if (obs() !== dec_v) begin
            $display("FAIL illegal_decode got=%h exp=%h", obs(), dec_v);
            failures++;
        end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        in = 16'h00FF; load = 1'b1; s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs() !== ex(0,1,0,0,0,0,0,2'b00,3'd0,3'd0,0,2'b00,2'b00) || sximm8 !== 16'h0000) begin
                $display("FAIL illegal_trap edge%0d got=%h/%h", i + 2, obs(), sximm8);
                failures++;
            end
        end
        load = 1'b0; s = 1'b0;
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        step();
        checks++;
        if (obs() !== idle_v) begin
            $display("FAIL illegal_recover got=%h exp=%h", obs(), idle_v);
            failures++;
        end
`else
        step();
        checks++;
        if (obs() !== idle_v) begin
            $display("FAIL illegal_return got=%h exp=%h", obs(), idle_v);
            failures++;
        end
`endif
    endtask

    task automatic test_back_to_back();
        // s held between instructions: next starts straight from WAIT
        issue(16'hD2FF);
        s = 1'b1; in = 16'hD37F; load = 1'b1;
        step();  // WR_IMM for first instruction, load ignored
        checks++;
        if (obs() !== ex(0,0,0,0,0,0,0,2'b10,3'd2,3'd0,1,2'b00,2'b00) || sximm8 !== 16'hFFFF) begin
            $display("FAIL b2b_first got=%h/%h", obs(), sximm8);
            failures++;
        end
        step();  // WAIT: captures D37F and launches
        step();  // DECODE with new IR
        s = 1'b0; load = 1'b0;
        checks++;
        if (obs() !== dec_v || sximm8 !== 16'h007F) begin
            $display("FAIL b2b_decode got=%h/%h exp=%h/007F", obs(), sximm8, dec_v);
            failures++;
        end
        step();
        checks++;
        if (obs() !== ex(0,0,0,0,0,0,0,2'b10,3'd3,3'd0,1,2'b00,2'b00)) begin
            $display("FAIL b2b_second got=%h", obs());
            failures++;
        end
        step();
    endtask

    initial begin
        idle_v = ex(1,0,0,0,0,0,0,2'b00,3'd0,3'd0,0,2'b00,2'b00);
        dec_v  = ex(0,0,0,0,0,0,0,2'b00,3'd0,3'd0,0,2'b00,2'b00);
        in = 16'h0000; load = 1'b0; s = 1'b0; reset_n = 1'b0;
        test_reset();
        test_mov_imm();
        test_add();
        test_mov_reg();
        test_cmp();
        test_mvn_reset_abort();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 in  in  16  instruction word presented for capture.
REQ-005 load  in  1  instruction register (IR) capture strobe.
REQ-006 s  in  1  start-execution request.
REQ-007 w  out  1  idle/ready flag.
REQ-008 err  out  1  illegal-instruction flag.
REQ-009 loada, loadb, loadc, loads  out  1 each  datapath register enables.
REQ-010 asel  out  1  1 = A operand forced to zero.
REQ-011 bsel  out  1  B operand select; always 0.
REQ-012 vsel  out  2  writeback select: 00 = C, 01 = PC, 10 = sximm8, 11 = mdata.
REQ-013 writenum, readnum  out  3 each  register-file write and read indices.
REQ-014 write  out  1  register-file write enable.
REQ-015 shift  out  2  shifter control.
REQ-016 ALUop  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = NOT B.
REQ-017 sximm8, sximm5  out  16 each  sign-extended immediates.

Function
REQ-018 IR fields SHALL be: opcode [15:13], op [12:11], Rn [10:8], Rd [7:5], sh [4:3], Rm [2:0], imm8 [7:0], imm5 [4:0].
REQ-019 IR SHALL capture `in` on a clock edge only when load=1 and the state is WAIT; load SHALL be ignored in all other states.
REQ-020 If load and s are sampled together in WAIT, DECODE SHALL use the newly captured IR.
REQ-021 Immediates: sximm8 = {8{IR[7]}, IR[7:0]}; sximm5 = {11{IR[4]}, IR[4:0]}; both combinational from IR.
REQ-022 Control outputs SHALL be combinational functions of state and IR (Moore); every output not listed for a state SHALL be 0.
REQ-023 Each state's enable takes effect at the edge leaving that state.
REQ-024 States SHALL be WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM and ERR.
REQ-025 WAIT: w=1; s=1 moves to DECODE; otherwise hold; s SHALL be ignored in every other state.
REQ-026 DECODE SHALL branch as follows:
- opcode 110, op 10 (MOV imm) -> WR_IMM.
- opcode 110, op 00 (MOV reg) -> GET_B.
- opcode 101, op 11 (MVN) -> GET_B.
- opcode 101, op 00/01/10 -> GET_A.
- any other opcode/op -> illegal handling (REQ-036).
REQ-027 GET_A SHALL drive readnum=Rn and loada=1, then go to GET_B.
REQ-028 GET_B SHALL drive readnum=Rm and loadb=1, then go to EXEC.
REQ-029 EXEC SHALL drive shift=sh and loadc=1, except for CMP (opcode 101, op 01), which SHALL drive loads=1 and loadc=0.
REQ-030 EXEC ALUop and asel:
- opcode 101: ALUop = op.
- MOV reg: ALUop = 00 and asel = 1.
REQ-031 EXEC SHALL go to WAIT for CMP and to WR_REG otherwise.
REQ-032 WR_REG SHALL drive vsel=00, writenum=Rd, write=1, then go to WAIT.
REQ-033 WR_IMM SHALL drive vsel=10, writenum=Rn, write=1, then go to WAIT.
REQ-034 Edges from s sampled to w=1: MOV imm 3, MOV reg 5, MVN 5, CMP 5, ADD/AND 6.

Reset
REQ-035 While reset_n=0, regardless of clk:
- state = WAIT, IR = 0, err = 0, w = 1, all enables 0.
- Assertion mid-instruction SHALL abort it; no write or loads pulse occurs afterwards.

Configuration
REQ-036 Macro CPU_CTRL_ILLEGAL_TRAP_EN SHALL select illegal-instruction handling:
- Defined: DECODE -> ERR on an illegal instruction; ERR holds err=1 and w=0 until reset.
- Undefined: DECODE -> WAIT with no enables asserted; err tied to 0.

Verification
REQ-037 Reset -> w=1, write=0, loads=0, err=0, sximm8=0x0000.
REQ-038 Load 0xD0FB (MOV R0,#-5), s=1 -> third edge writes with writenum=0, vsel=10, sximm8=0xFFFB; w=1 after the 3rd edge.
REQ-039 Load 0xA148 (ADD R2,R1,R0 LSL #1) -> successive states show readnum=1/loada, readnum=0/loadb, shift=01/ALUop=00/loadc, writenum=2/vsel=00/write; w returns after 6 edges.
REQ-040 Load 0xA900 (CMP R1,R0) -> EXEC shows ALUop=01, loads=1, loadc=0; write never asserted; w returns after 5 edges.
REQ-041 Load 0xB861 (MVN R3,R1), reset_n pulsed low during GET_B -> write never asserted, w=1, IR=0.
REQ-042 Load 0x0000, s=1 -> with macro: err=1, w=0 persistent, s ignored; without macro: w=1 after 2 edges, no enables asserted.
